// File: rtl/lidar_packet_tx.sv
// lidar_packet_tx
//   Serialises one LIDAR scan frame into a byte stream for a UART transmitter.
//   Frame layout (multi-byte fields LSB first):
//     HEADER, VER_LEN, speed[2], start_angle[2],
//     NUM_POINTS x {dist[2], intensity}, end_angle[2], timestamp[2], CRC
//   Total length is 3*NUM_POINTS+11 bytes.
//
//   Optional feature macro: LIDAR_TX_CRC_EN
//     defined   -> CRC byte is CRC-8 (poly 0x4D, init 0x00, MSB-first,
//                  no reflection, no final XOR) over all preceding bytes
//     undefined -> no CRC logic; CRC byte is sent as 8'h00
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   start_valid / start_ready       frame request handshake (ready only in IDLE)
//   speed, start_angle, end_angle,
//   timestamp                       frame fields, latched on start handshake
//   pt_valid / pt_ready             point handshake (ready only in PT_WAIT)
//   pt_dist, pt_intensity           point payload, latched on point handshake
//   out_valid / out_ready, out_data byte stream out
//   busy                            high while a frame is in progress
//   frame_done                      one-cycle pulse after the final byte handshake

module lidar_packet_tx #(
   parameter logic [7:0]  HEADER     = 8'h54,
   parameter logic [7:0]  VER_LEN    = 8'h2C,
   parameter int unsigned NUM_POINTS = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic [15:0] speed,
   input  logic [15:0] start_angle,
   input  logic [15:0] end_angle,
   input  logic [15:0] timestamp,
   input  logic        pt_valid,
   output logic        pt_ready,
   input  logic [15:0] pt_dist,
   input  logic [7:0]  pt_intensity,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        busy,
   output logic        frame_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_PT_WAIT, S_PT_BYTES, S_TAIL, S_CRC
   } state_t;

   localparam logic [4:0] LAST_PT = 5'(NUM_POINTS - 1);

   state_t      r_state;
   logic [2:0]  r_byte_idx;
   logic [4:0]  r_pt_idx;
   logic [15:0] r_speed, r_start_angle, r_end_angle, r_timestamp;
   logic [15:0] r_dist;
   logic [7:0]  r_inten;
   logic        r_out_valid, r_start_ready, r_pt_ready, r_busy, r_frame_done;
   logic [7:0]  r_out_data;

   logic        w_out_hs;
   logic        w_start_hs;
   logic [7:0]  w_hdr_next, w_pt_next, w_tail_next;
   logic [7:0]  w_crc_next;

   assign w_out_hs   = r_out_valid && out_ready;
   assign w_start_hs = (r_state == S_IDLE) && start_valid && r_start_ready;

   // Byte that follows the one currently on out_data, within each section.
   always_comb begin
      w_hdr_next  = VER_LEN;
      w_pt_next   = r_inten;
      w_tail_next = r_timestamp[15:8];
      unique case (r_byte_idx)
         3'd0:    w_hdr_next = VER_LEN;
         3'd1:    w_hdr_next = r_speed[7:0];
         3'd2:    w_hdr_next = r_speed[15:8];
         3'd3:    w_hdr_next = r_start_angle[7:0];
         default: w_hdr_next = r_start_angle[15:8];
      endcase
      if (r_byte_idx == 3'd0) w_pt_next = r_dist[15:8];
      unique case (r_byte_idx)
         3'd0:    w_tail_next = r_end_angle[15:8];
         3'd1:    w_tail_next = r_timestamp[7:0];
         default: w_tail_next = r_timestamp[15:8];
      endcase
   end

`ifdef LIDAR_TX_CRC_EN
   logic [7:0] r_crc;

   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] v;
      v = c ^ d;
      for (int unsigned i = 0; i < 8; i++)
         v = v[7] ? ((v << 1) ^ 8'h4D) : (v << 1);
      return v;
   endfunction

   // w_crc_next already folds in the byte being handed off, so the final
   // TAIL handshake can load it straight into out_data as the CRC byte.
   assign w_crc_next = crc8_step(r_crc, r_out_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_crc <= '0;
      else if (w_start_hs)
         r_crc <= '0;
      else if (w_out_hs && (r_state != S_CRC))
         r_crc <= w_crc_next;
   end
`else
   assign w_crc_next = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_byte_idx    <= '0;
         r_pt_idx      <= '0;
         r_speed       <= '0;
         r_start_angle <= '0;
         r_end_angle   <= '0;
         r_timestamp   <= '0;
         r_dist        <= '0;
         r_inten       <= '0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_start_ready <= 1'b1;
         r_pt_ready    <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_done  <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               // Held low through the frame_done cycle, so frames are
               // always separated by at least one idle cycle.
               r_start_ready <= 1'b1;
               if (w_start_hs) begin
                  r_speed       <= speed;
                  r_start_angle <= start_angle;
                  r_end_angle   <= end_angle;
                  r_timestamp   <= timestamp;
                  r_byte_idx    <= '0;
                  r_pt_idx      <= '0;
                  r_out_valid   <= 1'b1;
                  r_out_data    <= HEADER;
                  r_start_ready <= 1'b0;
                  r_busy        <= 1'b1;
                  r_state       <= S_HDR;
               end
            end
            S_HDR: if (w_out_hs) begin
               if (r_byte_idx == 3'd5) begin
                  r_byte_idx  <= '0;
                  r_out_valid <= 1'b0;
                  r_pt_ready  <= 1'b1;
                  r_state     <= S_PT_WAIT;
               end else begin
                  r_byte_idx <= r_byte_idx + 3'd1;
                  r_out_data <= w_hdr_next;
               end
            end
            S_PT_WAIT: if (pt_valid) begin
               r_dist      <= pt_dist;
               r_inten     <= pt_intensity;
               r_byte_idx  <= '0;
               r_out_valid <= 1'b1;
               r_out_data  <= pt_dist[7:0];
               r_pt_ready  <= 1'b0;
               r_state     <= S_PT_BYTES;
            end
            S_PT_BYTES: if (w_out_hs) begin
               if (r_byte_idx == 3'd2) begin
                  r_byte_idx <= '0;
                  if (r_pt_idx == LAST_PT) begin
                     r_out_data <= r_end_angle[7:0];
                     r_state    <= S_TAIL;
                  end else begin
                     r_pt_idx    <= r_pt_idx + 5'd1;
                     r_out_valid <= 1'b0;
                     r_pt_ready  <= 1'b1;
                     r_state     <= S_PT_WAIT;
                  end
               end else begin
                  r_byte_idx <= r_byte_idx + 3'd1;
                  r_out_data <= w_pt_next;
               end
            end
            S_TAIL: if (w_out_hs) begin
               if (r_byte_idx == 3'd3) begin
                  r_byte_idx <= '0;
                  r_out_data <= w_crc_next;
                  r_state    <= S_CRC;
               end else begin
                  r_byte_idx <= r_byte_idx + 3'd1;
                  r_out_data <= w_tail_next;
               end
            end
            S_CRC: if (w_out_hs) begin
               r_out_valid  <= 1'b0;
               r_out_data   <= '0;
               r_busy       <= 1'b0;
               r_pt_idx     <= '0;
               r_frame_done <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign start_ready = r_start_ready;
   assign pt_ready    = r_pt_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign busy        = r_busy;
   assign frame_done  = r_frame_done;

endmodule

// File: doc/lidar_packet_tx.md
LIDAR_PACKET_TX -- requirements
Module: lidar_packet_tx

Interface
REQ-001 SHALL have parameter HEADER, default 8'h54: frame byte 0.
REQ-002 SHALL have parameter VER_LEN, default 8'h2C: frame byte 1.
REQ-003 SHALL have parameter NUM_POINTS, default 12: points per frame, legal range 1..31.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start_valid  input  1  frame request; start_ready  output  1  high only in IDLE.
REQ-007 speed, start_angle, end_angle, timestamp  input  16 each  frame fields, latched on start handshake.
REQ-008 pt_valid  input  1; pt_ready  output  1; pt_dist  input  16 (mm); pt_intensity  input  8.
REQ-009 out_valid  output  1; out_ready  input  1; out_data  output  8  byte stream to the UART transmitter.
REQ-010 busy  output  1  high outside IDLE; frame_done  output  1  one-cycle pulse after the final byte handshake.

Function
REQ-011 SHALL emit (3*NUM_POINTS+11) bytes per frame, LSB first per field: HEADER, VER_LEN, speed[2], start_angle[2], NUM_POINTS x {dist[2], intensity}, end_angle[2], timestamp[2], CRC.
REQ-012 Start handshake SHALL be start_valid && start_ready; the fields SHALL be registered that cycle, and later input changes SHALL not affect the frame.
REQ-013 FSM states: IDLE -> HDR (bytes 0-5) -> PT_WAIT -> PT_BYTES (3 bytes) -> PT_WAIT, or TAIL after the last point -> TAIL (4 bytes) -> CRC (1 byte) -> IDLE.
REQ-014 pt_ready SHALL be high only in PT_WAIT.
REQ-015 On pt_valid && pt_ready, dist and intensity SHALL be latched and the FSM SHALL enter PT_BYTES.
REQ-016 A point index counter SHALL count 0..NUM_POINTS-1 and reset to 0 at frame start.
REQ-017 out_valid SHALL be high in HDR, PT_BYTES, TAIL and CRC, and low in IDLE and PT_WAIT.
REQ-018 While out_valid && !out_ready, out_data SHALL hold stable.
REQ-019 A byte SHALL advance only on out_valid && out_ready, so throughput is one byte per cycle with out_ready held high.
REQ-020 Latency: the first byte (HEADER) SHALL appear on out_data with out_valid the cycle after the start handshake.
REQ-021 Byte and point counters SHALL never wrap within a frame; the final CRC handshake SHALL return the FSM to IDLE and pulse frame_done the next cycle.
REQ-022 start_ready SHALL go high in the cycle after frame_done is asserted, so back-to-back frames are separated by at least one idle cycle.
REQ-023 start_valid asserted while busy SHALL be ignored (not queued).
REQ-024 The angle fields SHALL pass through unmodified, with no range check and no wrap correction; end_angle < start_angle is legal.

Reset
REQ-025 While rst_n=0: state IDLE, out_valid=0, out_data=0, pt_ready=0, busy=0, frame_done=0, counters=0, CRC=0, latched fields=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately; no partial byte or frame_done SHALL follow after release.
REQ-027 start_ready SHALL be 1 from the first cycle after rst_n deasserts.

Configuration
REQ-028 With macro LIDAR_TX_CRC_EN defined, the CRC byte SHALL be CRC-8, poly 0x4D, init 0x00, MSB-first, no reflection, no final XOR, over all preceding frame bytes.
REQ-029 With LIDAR_TX_CRC_EN defined, CRC SHALL update on each byte handshake and reinitialise at each start handshake.
REQ-030 Without LIDAR_TX_CRC_EN, the CRC logic SHALL be absent and the CRC byte SHALL be 8'h00; frame length is unchanged.

Verification
REQ-031 Stimulus: speed=0x0E14, start=0x4953, end=0x4CBF, ts=0x70CA, 12 points starting {0x00C5,0xF3}, {0x00BD,0xF0}, out_ready=1, CRC enabled -> 47 bytes 54 2C 14 0E 53 49 C5 00 F3 BD 00 F0 ... BF 4C CA 70 88.
REQ-032 Same frame, out_ready toggled 1-of-3 cycles -> identical byte sequence; out_data stable whenever out_valid && !out_ready.
REQ-033 Delay pt_valid by 50 cycles before point 5 -> out_valid=0 for those cycles, pt_ready=1 held, byte order unchanged.
REQ-034 start_valid pulsed mid-frame and again after frame_done -> the first pulse is ignored; the second frame starts with 54 2C only after start_ready=1.
REQ-035 rst_n=0 at byte 20 then released -> out_valid=0 and busy=0 immediately; a new frame then starts at byte 0 with CRC recomputed from 0x00.
REQ-036 CRC disabled build with the REQ-031 stimulus -> bytes 0..45 identical to REQ-031, byte 46 = 0x00.
